// File: rtl/pr_freeze_bridge.sv
// pr_freeze_bridge
//
// Static-region stage that sits in front of a PR region's avs_ctrl slave. In normal
// operation host Avalon-MM control traffic passes straight through. On freeze_req the
// bridge stops issuing commands, waits for outstanding downstream reads to return, then
// runs the stop_req/stop_ack handshake. While frozen the PR region is isolated: host
// writes are dropped and host reads are answered locally with DEAD_DATA. Releasing
// freeze_req runs the start_req/start_ack handshake and resumes pass-through.
//
// Optional feature macro: PR_FREEZE_TIMEOUT_EN
//   defined   - a 16-bit counter bounds each handshake to TIMEOUT_CYCLES cycles. On
//               expiry pr_error is set (sticky) and the FSM advances anyway.
//   undefined - handshakes wait forever; pr_error is tied 0.
//
// Ports:
//   clk_clk, reset_reset        clock, synchronous active-high reset
//   s_*                         host-facing Avalon-MM slave
//   m_*                         PR-region-facing Avalon-MM master (m_debugaccess tied 0)
//   freeze_req                  level request from the PR controller
//   freeze_status               high only while frozen
//   pr_error                    sticky handshake-timeout flag
//   pr_handshake_stop_*/start_* PR region freeze handshake

module pr_freeze_bridge #(
    parameter int unsigned MAX_PEND       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter logic [63:0] DEAD_DATA      = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic        clk_clk,
    input  logic        reset_reset,

    input  logic [15:0] s_address,
    input  logic [63:0] s_writedata,
    input  logic [7:0]  s_byteenable,
    input  logic        s_burstcount,
    input  logic        s_read,
    input  logic        s_write,
    output logic        s_waitrequest,
    output logic [63:0] s_readdata,
    output logic        s_readdatavalid,

    output logic [15:0] m_address,
    output logic [63:0] m_writedata,
    output logic [7:0]  m_byteenable,
    output logic        m_burstcount,
    output logic        m_read,
    output logic        m_write,
    output logic        m_debugaccess,
    input  logic        m_waitrequest,
    input  logic [63:0] m_readdata,
    input  logic        m_readdatavalid,

    input  logic        freeze_req,
    output logic        freeze_status,
    output logic        pr_error,

    output logic        pr_handshake_stop_req,
    output logic        pr_handshake_start_req,
    input  logic        pr_handshake_stop_ack,
    input  logic        pr_handshake_start_ack
);

    typedef enum logic [2:0] {StRun, StDrain, StStop, StFrozen, StStart} state_t;

    localparam logic [3:0] MaxPendW = 4'(MAX_PEND);

    state_t     state;
    logic [3:0] pending;
    logic [3:0] pending_nxt;
    logic       frz_rdv;     // local read response, one cycle after a frozen read
    logic       pend_full;
    logic       rd_acc;
    logic       tmo_hit;

    assign pend_full = (pending == MaxPendW);

    // Command path: buses always follow the host, strobes only in RUN.
    assign m_address     = s_address;
    assign m_writedata   = s_writedata;
    assign m_byteenable  = s_byteenable;
    assign m_burstcount  = s_burstcount;
    assign m_debugaccess = 1'b0;

    always_comb begin
        m_read        = 1'b0;
        m_write       = 1'b0;
        s_waitrequest = 1'b1;
        case (state)
            StRun: begin
                m_read        = s_read & ~pend_full;
                m_write       = s_write;
                s_waitrequest = m_waitrequest | (s_read & pend_full);
            end
            StFrozen: s_waitrequest = 1'b0;
            default:  s_waitrequest = 1'b1;
        endcase
    end

    assign rd_acc = m_read & ~m_waitrequest;

    // Decrement is guarded so a stray downstream response can never wrap the counter.
    always_comb begin
        pending_nxt = pending;
        if (rd_acc && !m_readdatavalid) begin
            pending_nxt = pending + 4'd1;
        end else if (!rd_acc && m_readdatavalid && pending != 4'd0) begin
            pending_nxt = pending - 4'd1;
        end
    end

    // Return path: downstream data except while frozen, where the answer is local.
    assign s_readdatavalid = frz_rdv | ((state != StFrozen) & m_readdatavalid);
    assign s_readdata      = (frz_rdv || state == StFrozen) ? DEAD_DATA : m_readdata;

`ifdef PR_FREEZE_TIMEOUT_EN
    localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt;
    logic        tmo_wait;
    logic        err;

    assign tmo_wait = (state == StStop  && !pr_handshake_stop_ack) ||
                      (state == StStart && !pr_handshake_start_ack);
    assign tmo_hit  = tmo_wait && (tmo_cnt == TmoLast);
    assign pr_error = err;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            tmo_cnt <= 16'd0;
            err     <= 1'b0;
        end else begin
            tmo_cnt <= (tmo_wait && !tmo_hit) ? tmo_cnt + 16'd1 : 16'd0;
            if (state == StRun && freeze_req) begin
                err <= 1'b0;
            end else if (tmo_hit) begin
                err <= 1'b1;
            end
        end
    end
`else
    // TIMEOUT_CYCLES has no effect in this build.
    localparam bit TmoUnused = (TIMEOUT_CYCLES != 0);

    assign tmo_hit  = 1'b0;
    assign pr_error = TmoUnused & 1'b0;
`endif

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state                  <= StRun;
            pending                <= 4'd0;
            frz_rdv                <= 1'b0;
            freeze_status          <= 1'b0;
            pr_handshake_stop_req  <= 1'b0;
            pr_handshake_start_req <= 1'b0;
        end else begin
            pending <= pending_nxt;
            frz_rdv <= (state == StFrozen) & s_read;
            unique case (state)
                StRun: begin
                    if (freeze_req) begin
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    // Look at the post-update count so stop_req follows the last
                    // downstream response by exactly one cycle.
                    if (pending_nxt == 4'd0) begin
                        state                 <= StStop;
                        pr_handshake_stop_req <= 1'b1;
                    end
                end
                StStop: begin
                    if (pr_handshake_stop_ack || tmo_hit) begin
                        state                 <= StFrozen;
                        pr_handshake_stop_req <= 1'b0;
                        freeze_status         <= 1'b1;
                    end
                end
                StFrozen: begin
                    if (!freeze_req) begin
                        state                  <= StStart;
                        freeze_status          <= 1'b0;
                        pr_handshake_start_req <= 1'b1;
                    end
                end
                StStart: begin
                    if (pr_handshake_start_ack || tmo_hit) begin
                        state                  <= StRun;
                        pr_handshake_start_req <= 1'b0;
                    end
                end
                default: state <= StRun;
            endcase
        end
    end

endmodule
